change_dispenser: RTL and testbench

Payout engine at the far end of the vending machine's change interface. It accepts a change amount in quarter units from the vending controller and decomposes it greedily into dollar, half and quarter coins. It ejects the coins one at a time into the coin hopper under a ready/pulse handshake, tracks per-denomination coin inventory, and reports completion or shortfall.

---
 rtl/vending_pkg.sv | 28 ++
 rtl/change_dispenser_if.sv | 32 +++
 rtl/change_coin_select.sv | 41 ++++
 rtl/change_dispenser.sv | 118 +++++++++++
 tb/tb_change_dispenser.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/vending_pkg.sv
// Shared vending-machine types: coin values in quarter units, payout FSM encoding, coin select.
package vending_pkg;

  localparam int unsigned COIN_1   = 4;
  localparam int unsigned COIN_05  = 2;
  localparam int unsigned COIN_025 = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PAY  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic c1;
    logic c05;
    logic c025;
  } coin_sel_t;

  function automatic logic [15:0] coin_value(input coin_sel_t s);
    if (s.c1)        return 16'(COIN_1);
    else if (s.c05)  return 16'(COIN_05);
    else if (s.c025) return 16'(COIN_025);
    else             return 16'd0;
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Change interface between the vending controller / coin hopper and the payout engine.
interface change_dispenser_if #(
    parameter int CNT_W = 8
) ();
    logic             in_start;
    logic [15:0]      in_change_amt;
    logic             in_refill;
    logic             in_hopper_ready;
    logic             out_pay_1;
    logic             out_pay_05;
    logic             out_pay_025;
    logic             out_busy;
    logic             out_done;
    logic             out_short;
    logic [15:0]      out_owed;
    logic [CNT_W-1:0] out_inv_1;
    logic [CNT_W-1:0] out_inv_05;
    logic [CNT_W-1:0] out_inv_025;
    logic [1:0]       out_state;

    modport slave (
        input  in_start, in_change_amt, in_refill, in_hopper_ready,
        output out_pay_1, out_pay_05, out_pay_025, out_busy, out_done, out_short,
               out_owed, out_inv_1, out_inv_05, out_inv_025, out_state
    );

    modport master (
        output in_start, in_change_amt, in_refill, in_hopper_ready,
        input  out_pay_1, out_pay_05, out_pay_025, out_busy, out_done, out_short,
               out_owed, out_inv_1, out_inv_05, out_inv_025, out_state
    );
endinterface

// File: rtl/change_coin_select.sv
// Greedy coin picker (combinational). Define CHANGE_SUBSTITUTE_EN to fall back to smaller
// in-stock coins when the preferred denomination is empty.
module change_coin_select
    import vending_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic [15:0]      owed,
    input  logic [CNT_W-1:0] inv_1,
    input  logic [CNT_W-1:0] inv_05,
    input  logic [CNT_W-1:0] inv_025,
    output coin_sel_t        sel,
    output logic             none
);

`ifdef CHANGE_SUBSTITUTE_EN
    always_comb begin
        sel = '0;
        if (owed >= 16'(COIN_1) && inv_1 != '0)
            sel.c1 = 1'b1;
        else if (owed >= 16'(COIN_05) && inv_05 != '0)
            sel.c05 = 1'b1;
        else if (owed >= 16'(COIN_025) && inv_025 != '0)
            sel.c025 = 1'b1;
    end
`else
    // Only the largest coin <= owed is eligible; an empty tube means nothing to pay with.
    always_comb begin
        sel = '0;
        if (owed >= 16'(COIN_1))
            sel.c1 = (inv_1 != '0);
        else if (owed >= 16'(COIN_05))
            sel.c05 = (inv_05 != '0);
        else if (owed >= 16'(COIN_025))
            sel.c025 = (inv_025 != '0);
    end
`endif

    assign none = (sel == '0);

endmodule

// File: rtl/change_dispenser.sv
// Change payout engine: greedy dollar/half/quarter ejection with inventory tracking.
// Coin substitution is enabled by defining CHANGE_SUBSTITUTE_EN (see change_coin_select).
module change_dispenser
    import vending_pkg::*;
#(
    parameter int INIT_1   = 20,
    parameter int INIT_05  = 20,
    parameter int INIT_025 = 40,
    parameter int CNT_W    = 8
) (
    input  logic               in_clka,
    input  logic               in_restart,
    change_dispenser_if.slave  bus
);

    state_t           state;
    logic [15:0]      owed;
    logic [CNT_W-1:0] inv_1, inv_05, inv_025;
    logic             pay_1, pay_05, pay_025;
    logic             busy, done, short_r;

    coin_sel_t sel;
    logic      none;

    change_coin_select #(.CNT_W(CNT_W)) u_sel (
        .owed    (owed),
        .inv_1   (inv_1),
        .inv_05  (inv_05),
        .inv_025 (inv_025),
        .sel     (sel),
        .none    (none)
    );

    always_ff @(posedge in_clka) begin
        if (in_restart) begin
            state   <= ST_IDLE;
            owed    <= '0;
            inv_1   <= CNT_W'(INIT_1);
            inv_05  <= CNT_W'(INIT_05);
            inv_025 <= CNT_W'(INIT_025);
            pay_1   <= 1'b0;
            pay_05  <= 1'b0;
            pay_025 <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            short_r <= 1'b0;
        end else begin
            pay_1   <= 1'b0;
            pay_05  <= 1'b0;
            pay_025 <= 1'b0;
            done    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.in_refill) begin
                        inv_1   <= CNT_W'(INIT_1);
                        inv_05  <= CNT_W'(INIT_05);
                        inv_025 <= CNT_W'(INIT_025);
                    end
                    if (bus.in_start) begin
                        if ($signed(bus.in_change_amt) > 16'sd0) begin
                            owed    <= bus.in_change_amt;
                            short_r <= 1'b0;
                            busy    <= 1'b1;
                            state   <= ST_PAY;
                        end else begin
                            // Zero is a trivial success; a negative amount is reported as short.
                            owed    <= '0;
                            short_r <= bus.in_change_amt[15];
                            done    <= 1'b1;
                            state   <= ST_DONE;
                        end
                    end
                end
                ST_PAY: begin
                    if (none) begin
                        short_r <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_DONE;
                    end else if (bus.in_hopper_ready) begin
                        pay_1   <= sel.c1;
                        pay_05  <= sel.c05;
                        pay_025 <= sel.c025;
                        if (sel.c1)   inv_1   <= inv_1   - CNT_W'(1);
                        if (sel.c05)  inv_05  <= inv_05  - CNT_W'(1);
                        if (sel.c025) inv_025 <= inv_025 - CNT_W'(1);
                        owed    <= owed - coin_value(sel);
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (owed != '0) begin
                        state <= ST_PAY;
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.out_pay_1   = pay_1;
    assign bus.out_pay_05  = pay_05;
    assign bus.out_pay_025 = pay_025;
    assign bus.out_busy    = busy;
    assign bus.out_done    = done;
    assign bus.out_short   = short_r;
    assign bus.out_owed    = owed;
    assign bus.out_inv_1   = inv_1;
    assign bus.out_inv_05  = inv_05;
    assign bus.out_inv_025 = inv_025;
    assign bus.out_state   = state;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: default-inventory DUT plus a one-dollar-coin DUT.
module tb_change_dispenser;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    change_dispenser_if #(.CNT_W(8)) ifa ();
    change_dispenser_if #(.CNT_W(8)) ifb ();

    change_dispenser dut_a (.in_clka(clk), .in_restart(rst), .bus(ifa));
    change_dispenser #(.INIT_1(1)) dut_b (.in_clka(clk), .in_restart(rst), .bus(ifb));

    logic [2:0] pa, pb;
    assign pa = {ifa.out_pay_1, ifa.out_pay_05, ifa.out_pay_025};
    assign pb = {ifb.out_pay_1, ifb.out_pay_05, ifb.out_pay_025};

    int total = 0;
    int bad   = 0;
    logic [2:0] pq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] qat(input int k);
        return (k < pq.size()) ? pq[k] : 3'b111;
    endfunction

    // Runs until out_done (bounded), logging every pulse seen on the chosen DUT.
    task automatic collect(input bit b);
        int n = 0;
        bit seen = 1'b0;
        logic [2:0] p;
        pq.delete();
        while (!seen && n < 60) begin
            tick();
            n++;
            p = b ? pb : pa;
            if (p != 3'b000) begin
                pq.push_back(p);
                chk("onehot", $countones(p), 1);
            end
            seen = b ? ifb.out_done : ifa.out_done;
        end
        chk("done_seen", seen, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        ifa.in_start = 0; ifa.in_change_amt = 0; ifa.in_refill = 0; ifa.in_hopper_ready = 1;
        ifb.in_start = 0; ifb.in_change_amt = 0; ifb.in_refill = 0; ifb.in_hopper_ready = 1;
        tick(); tick();
        rst = 1'b0;

        // reset state
        chk("rst state", ifa.out_state, 0);
        chk("rst busy",  ifa.out_busy, 0);
        chk("rst done",  ifa.out_done, 0);
        chk("rst short", ifa.out_short, 0);
        chk("rst owed",  ifa.out_owed, 0);
        chk("rst pay",   pa, 0);
        chk("rst inv1",  ifa.out_inv_1, 20);
        chk("rst inv05", ifa.out_inv_05, 20);
        chk("rst inv025", ifa.out_inv_025, 40);
        chk("rst b inv1", ifb.out_inv_1, 1);

        // amt 7, ready held: dollar, half, quarter at 2-cycle spacing
        ifa.in_start = 1; ifa.in_change_amt = 16'd7;
        tick();
        ifa.in_start = 0;
        chk("t1 e0 state", ifa.out_state, 1);
        chk("t1 e0 owed", ifa.out_owed, 7);
        chk("t1 e0 busy", ifa.out_busy, 1);
        chk("t1 e0 pay", pa, 0);
        tick();
        chk("t1 e1 pay", pa, 3'b100);
        chk("t1 e1 state", ifa.out_state, 2);
        chk("t1 e1 owed", ifa.out_owed, 3);
        chk("t1 e1 inv1", ifa.out_inv_1, 19);
        tick();
        chk("t1 e2 state", ifa.out_state, 1);
        chk("t1 e2 pay", pa, 0);
        tick();
        chk("t1 e3 pay", pa, 3'b010);
        chk("t1 e3 owed", ifa.out_owed, 1);
        chk("t1 e3 inv05", ifa.out_inv_05, 19);
        tick();
        chk("t1 e4 pay", pa, 0);
        tick();
        chk("t1 e5 pay", pa, 3'b001);
        chk("t1 e5 owed", ifa.out_owed, 0);
        chk("t1 e5 inv025", ifa.out_inv_025, 39);
        tick();
        chk("t1 e6 state", ifa.out_state, 3);
        chk("t1 e6 done", ifa.out_done, 1);
        chk("t1 e6 short", ifa.out_short, 0);
        chk("t1 e6 busy", ifa.out_busy, 0);
        tick();
        chk("t1 e7 state", ifa.out_state, 0);
        chk("t1 e7 done", ifa.out_done, 0);

        // INIT_1 = 1, amt 8
        ifb.in_start = 1; ifb.in_change_amt = 16'd8;
        tick();
        ifb.in_start = 0;
        collect(1'b1);
        chk("t2 p0", qat(0), 3'b100);
        chk("t2 inv1", ifb.out_inv_1, 0);
`ifdef CHANGE_SUBSTITUTE_EN
        chk("t2 npulse", pq.size(), 3);
        chk("t2 p1", qat(1), 3'b010);
        chk("t2 p2", qat(2), 3'b010);
        chk("t2 owed", ifb.out_owed, 0);
        chk("t2 short", ifb.out_short, 0);
        chk("t2 inv05", ifb.out_inv_05, 18);
`else
        chk("t2 npulse", pq.size(), 1);
        chk("t2 owed", ifb.out_owed, 4);
        chk("t2 short", ifb.out_short, 1);
        chk("t2 inv05", ifb.out_inv_05, 20);
`endif
        tick();
        chk("t2 idle", ifb.out_state, 0);

        // amt 0 on dut_b: immediate done, short cleared
        ifb.in_start = 1; ifb.in_change_amt = 16'd0;
        tick();
        ifb.in_start = 0;
        chk("z state", ifb.out_state, 3);
        chk("z done", ifb.out_done, 1);
        chk("z short", ifb.out_short, 0);
        tick();

        // refill restores dut_b inventories
        ifb.in_refill = 1;
        tick();
        ifb.in_refill = 0;
        chk("rf inv1", ifb.out_inv_1, 1);
        chk("rf inv05", ifb.out_inv_05, 20);
        chk("rf inv025", ifb.out_inv_025, 40);

        // amt 3 with hopper stalled for 5 cycles
        ifa.in_hopper_ready = 0;
        ifa.in_start = 1; ifa.in_change_amt = 16'd3;
        tick();
        ifa.in_start = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3 stall state", ifa.out_state, 1);
            chk("t3 stall pay", pa, 0);
        end
        chk("t3 stall owed", ifa.out_owed, 3);
        ifa.in_hopper_ready = 1;
        collect(1'b0);
        chk("t3 npulse", pq.size(), 2);
        chk("t3 p0", qat(0), 3'b010);
        chk("t3 p1", qat(1), 3'b001);
        chk("t3 short", ifa.out_short, 0);
        chk("t3 inv05", ifa.out_inv_05, 18);
        chk("t3 inv025", ifa.out_inv_025, 38);
        tick();

        // amt -2: short, no pulses, inventories untouched
        ifa.in_start = 1; ifa.in_change_amt = 16'hFFFE;
        tick();
        ifa.in_start = 0;
        chk("t4 state", ifa.out_state, 3);
        chk("t4 done", ifa.out_done, 1);
        chk("t4 short", ifa.out_short, 1);
        chk("t4 owed", ifa.out_owed, 0);
        chk("t4 pay", pa, 0);
        chk("t4 inv1", ifa.out_inv_1, 19);
        chk("t4 inv05", ifa.out_inv_05, 18);
        chk("t4 inv025", ifa.out_inv_025, 38);
        tick();

        // amt 5 with a stray start(4) during PAY/WAIT
        ifa.in_start = 1; ifa.in_change_amt = 16'd5;
        tick();
        chk("t5 short clr", ifa.out_short, 0);
        ifa.in_change_amt = 16'd4;
        tick();
        chk("t5 e1 pay", pa, 3'b100);
        chk("t5 e1 owed", ifa.out_owed, 1);
        tick();
        chk("t5 e2 owed", ifa.out_owed, 1);
        chk("t5 e2 state", ifa.out_state, 1);
        ifa.in_start = 0;
        collect(1'b0);
        chk("t5 npulse", pq.size(), 1);
        chk("t5 p0", qat(0), 3'b001);
        chk("t5 owed", ifa.out_owed, 0);
        chk("t5 inv1", ifa.out_inv_1, 18);
        chk("t5 inv025", ifa.out_inv_025, 37);
        tick();

        // restart in the cycle after the first pulse
        ifa.in_start = 1; ifa.in_change_amt = 16'd7;
        tick();
        ifa.in_start = 0;
        tick();
        chk("t6 pulse", pa, 3'b100);
        chk("t6 inv1 pre", ifa.out_inv_1, 17);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6 state", ifa.out_state, 0);
        chk("t6 pay", pa, 0);
        chk("t6 busy", ifa.out_busy, 0);
        chk("t6 done", ifa.out_done, 0);
        chk("t6 short", ifa.out_short, 0);
        chk("t6 owed", ifa.out_owed, 0);
        chk("t6 inv1", ifa.out_inv_1, 20);
        chk("t6 inv05", ifa.out_inv_05, 20);
        chk("t6 inv025", ifa.out_inv_025, 40);
        tick();
        chk("t6 stays idle", ifa.out_state, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
